// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-subset core: datapath sizes, opcode/funct
// encodings and the instruction classification used by the decode/EX boundary.
package mips_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [2:0] {
        CLS_BAD,
        CLS_RTYPE,
        CLS_ADDI,
        CLS_ANDI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } instr_class_e;

    function automatic instr_class_e decode_class(input logic [5:0] opcode);
        case (opcode)
            OP_RTYPE: return CLS_RTYPE;
            OP_ADDI:  return CLS_ADDI;
            OP_ANDI:  return CLS_ANDI;
            OP_LW:    return CLS_LOAD;
            OP_SW:    return CLS_STORE;
            OP_BEQ:   return CLS_BRANCH;
            default:  return CLS_BAD;
        endcase
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass: picks the youngest in-flight write to a source register,
// EX/MEM over MEM/WB over the register file; r0 always reads as zero.
module fwd_mux #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] src_idx,
    input  logic [DW-1:0] rf_data,
    input  logic          exm_wr_en,
    input  logic [RW-1:0] exm_wr_idx,
    input  logic [DW-1:0] exm_wr_data,
    input  logic          mwb_wr_en,
    input  logic [RW-1:0] mwb_wr_idx,
    input  logic [DW-1:0] mwb_wr_data,
    output logic [DW-1:0] fwd_data
);

    always_comb begin
        if (src_idx == '0)
            fwd_data = '0;
        else if (exm_wr_en && (exm_wr_idx == src_idx))
            fwd_data = exm_wr_data;
        else if (mwb_wr_en && (mwb_wr_idx == src_idx))
            fwd_data = mwb_wr_data;
        else
            fwd_data = rf_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards and registers operands, forms immediates
// and control for the ALU, and inserts a single bubble on a load-use hazard.
module id_ex_stage #(
    parameter int DW = mips_pkg::DW,
    parameter int RW = mips_pkg::RW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [5:0]    id_opcode,
    input  logic [5:0]    id_funct,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [15:0]   id_imm,
    input  logic          exm_wr_en,
    input  logic [RW-1:0] exm_wr_idx,
    input  logic [DW-1:0] exm_wr_data,
    input  logic          mwb_wr_en,
    input  logic [RW-1:0] mwb_wr_idx,
    input  logic [DW-1:0] mwb_wr_data,
    input  logic          flush,
    output logic          hazard_stall,
    output logic          ex_valid,
    output logic [DW-1:0] ex_op1,
    output logic [DW-1:0] ex_op2,
    output logic [5:0]    ex_sel,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_branch
);
    import mips_pkg::*;

    instr_class_e        id_cls;
    logic                reads_rt;
    logic [1:0][RW-1:0]  src_idx;
    logic [1:0][DW-1:0]  src_rf;
    logic [1:0][DW-1:0]  src_fwd;
    logic [DW-1:0]       imm_sext;
    logic [DW-1:0]       imm_zext;
    logic                writes_rd;

    logic          valid_reg, valid_next;
    logic [DW-1:0] op1_reg, op1_next;
    logic [DW-1:0] op2_reg, op2_next;
    logic [5:0]    sel_reg, sel_next;
    logic [DW-1:0] store_reg, store_next;
    logic [RW-1:0] dest_reg, dest_next;
    logic          reg_write_reg, reg_write_next;
    logic          mem_read_reg, mem_read_next;
    logic          mem_write_reg, mem_write_next;
    logic          branch_reg, branch_next;

    assign src_idx = {id_rt, id_rs};
    assign src_rf  = {id_rt_data, id_rs_data};

    // Index 0 resolves rs, index 1 resolves rt.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        fwd_mux #(.DW(DW), .RW(RW)) u_fwd (
            .src_idx     (src_idx[gi]),
            .rf_data     (src_rf[gi]),
            .exm_wr_en   (exm_wr_en),
            .exm_wr_idx  (exm_wr_idx),
            .exm_wr_data (exm_wr_data),
            .mwb_wr_en   (mwb_wr_en),
            .mwb_wr_idx  (mwb_wr_idx),
            .mwb_wr_data (mwb_wr_data),
            .fwd_data    (src_fwd[gi])
        );
    end

    assign id_cls   = decode_class(id_opcode);
    assign reads_rt = (id_cls == CLS_RTYPE) || (id_cls == CLS_STORE) || (id_cls == CLS_BRANCH);
    assign imm_sext = {{(DW-16){id_imm[15]}}, id_imm};
    assign imm_zext = {{(DW-16){1'b0}}, id_imm};

    // The load result only exists after MEM, so a consumer directly behind it waits one cycle.
    assign hazard_stall = !reset && valid_reg && mem_read_reg && (dest_reg != '0) && id_valid
                          && ((dest_reg == id_rs) || ((dest_reg == id_rt) && reads_rt));

    always_comb begin
        valid_next     = 1'b0;
        op1_next       = '0;
        op2_next       = '0;
        sel_next       = '0;
        store_next     = '0;
        dest_next      = '0;
        writes_rd      = 1'b0;
        reg_write_next = 1'b0;
        mem_read_next  = 1'b0;
        mem_write_next = 1'b0;
        branch_next    = 1'b0;
        if (!flush && !hazard_stall && id_valid && (id_cls != CLS_BAD)) begin
            valid_next = 1'b1;
            op1_next   = src_fwd[0];
            store_next = src_fwd[1];
            sel_next   = id_opcode;
            case (id_cls)
                CLS_RTYPE: begin
                    op2_next  = src_fwd[1];
                    sel_next  = id_funct;
                    dest_next = id_rd;
                    writes_rd = 1'b1;
                end
                CLS_ADDI: begin
                    op2_next  = imm_sext;
                    dest_next = id_rt;
                    writes_rd = 1'b1;
                end
                CLS_ANDI: begin
                    op2_next  = imm_zext;
                    dest_next = id_rt;
                    writes_rd = 1'b1;
                end
                CLS_LOAD: begin
                    op2_next      = imm_sext;
                    dest_next     = id_rt;
                    writes_rd     = 1'b1;
                    mem_read_next = 1'b1;
                end
                CLS_STORE: begin
                    op2_next       = imm_sext;
                    mem_write_next = 1'b1;
                end
                CLS_BRANCH: begin
                    op2_next    = src_fwd[1];
                    branch_next = 1'b1;
                end
                default: ;
            endcase
            reg_write_next = writes_rd && (dest_next != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg     <= 1'b0;
            op1_reg       <= '0;
            op2_reg       <= '0;
            sel_reg       <= '0;
            store_reg     <= '0;
            dest_reg      <= '0;
            reg_write_reg <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            branch_reg    <= 1'b0;
        end else begin
            valid_reg     <= valid_next;
            op1_reg       <= op1_next;
            op2_reg       <= op2_next;
            sel_reg       <= sel_next;
            store_reg     <= store_next;
            dest_reg      <= dest_next;
            reg_write_reg <= reg_write_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            branch_reg    <= branch_next;
        end
    end

    assign ex_valid      = valid_reg;
    assign ex_op1        = op1_reg;
    assign ex_op2        = op2_reg;
    assign ex_sel        = sel_reg;
    assign ex_store_data = store_reg;
    assign ex_dest       = dest_reg;
    assign ex_reg_write  = reg_write_reg;
    assign ex_mem_read   = mem_read_reg;
    assign ex_mem_write  = mem_write_reg;
    assign ex_branch     = branch_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: hand-computed vectors for capture, immediates,
// forwarding priority, load-use bubble, flush and asynchronous reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic        exm_wr_en;
    logic [4:0]  exm_wr_idx;
    logic [31:0] exm_wr_data;
    logic        mwb_wr_en;
    logic [4:0]  mwb_wr_idx;
    logic [31:0] mwb_wr_data;
    logic        flush;
    logic        hazard_stall, ex_valid;
    logic [31:0] ex_op1, ex_op2, ex_store_data;
    logic [5:0]  ex_sel;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_funct      (id_funct),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_imm        (id_imm),
        .exm_wr_en     (exm_wr_en),
        .exm_wr_idx    (exm_wr_idx),
        .exm_wr_data   (exm_wr_data),
        .mwb_wr_en     (mwb_wr_en),
        .mwb_wr_idx    (mwb_wr_idx),
        .mwb_wr_data   (mwb_wr_data),
        .flush         (flush),
        .hazard_stall  (hazard_stall),
        .ex_valid      (ex_valid),
        .ex_op1        (ex_op1),
        .ex_op2        (ex_op2),
        .ex_sel        (ex_sel),
        .ex_store_data (ex_store_data),
        .ex_dest       (ex_dest),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_branch     (ex_branch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [5:0] op, input logic [5:0] fn,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
        id_valid   = v;
        id_opcode  = op;
        id_funct   = fn;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_rs_data = rsd;
        id_rt_data = rtd;
        id_imm     = imm;
    endtask

    task automatic no_fwd();
        exm_wr_en = 1'b0; exm_wr_idx = '0; exm_wr_data = '0;
        mwb_wr_en = 1'b0; mwb_wr_idx = '0; mwb_wr_data = '0;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, " valid"}, {31'd0, ex_valid}, 32'd0);
        check({tag, " ctrl"}, {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 32'd0);
        check({tag, " op1"}, ex_op1, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        no_fwd();
        set_instr(1'b1, 6'b100011, 6'd0, 5'd1, 5'd5, 5'd0, 32'd0, 32'd0, 16'd0);
        tick(); tick();
        check("reset hazard", {31'd0, hazard_stall}, 32'd0);
        check("reset valid", {31'd0, ex_valid}, 32'd0);
        set_instr(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0);
        reset = 1'b0;
        tick();
        check_bubble("idle");
        check("idle dest", {27'd0, ex_dest}, 32'd0);

        // add r3 = r1 + r2
        set_instr(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0);
        tick();
        check("add valid", {31'd0, ex_valid}, 32'd1);
        check("add op1", ex_op1, 32'd5);
        check("add op2", ex_op2, 32'd7);
        check("add sel", {26'd0, ex_sel}, 32'h20);
        check("add dest", {27'd0, ex_dest}, 32'd3);
        check("add ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 32'b1000);

        // andi zero-extends, addi sign-extends
        set_instr(1'b1, 6'b001100, 6'd0, 5'd1, 5'd7, 5'd0, 32'h1234_5678, 32'd0, 16'hFFFF);
        tick();
        check("andi op1", ex_op1, 32'h1234_5678);
        check("andi op2", ex_op2, 32'h0000_FFFF);
        check("andi sel", {26'd0, ex_sel}, 32'h0C);
        check("andi dest", {27'd0, ex_dest}, 32'd7);
        set_instr(1'b1, 6'b001000, 6'd0, 5'd1, 5'd8, 5'd0, 32'd3, 32'd0, 16'hFFFF);
        tick();
        check("addi op2", ex_op2, 32'hFFFF_FFFF);
        check("addi sel", {26'd0, ex_sel}, 32'h08);
        set_instr(1'b1, 6'b001000, 6'd0, 5'd1, 5'd0, 5'd0, 32'd3, 32'd0, 16'd1);
        tick();
        check("addi r0 valid", {31'd0, ex_valid}, 32'd1);
        check("addi r0 regwr", {31'd0, ex_reg_write}, 32'd0);

        // forwarding priority
        set_instr(1'b1, 6'b000000, 6'b100000, 5'd4, 5'd9, 5'd10, 32'h11, 32'h22, 16'd0);
        exm_wr_en = 1'b1; exm_wr_idx = 5'd4; exm_wr_data = 32'hAA;
        mwb_wr_en = 1'b1; mwb_wr_idx = 5'd4; mwb_wr_data = 32'hBB;
        tick();
        check("fwd exm op1", ex_op1, 32'hAA);
        check("fwd none op2", ex_op2, 32'h22);
        exm_wr_en = 1'b0;
        tick();
        check("fwd mwb op1", ex_op1, 32'hBB);
        set_instr(1'b1, 6'b000000, 6'b100000, 5'd0, 5'd9, 5'd10, 32'h55, 32'h22, 16'd0);
        exm_wr_en = 1'b1; exm_wr_idx = 5'd0; mwb_wr_idx = 5'd0;
        tick();
        check("fwd r0 op1", ex_op1, 32'd0);
        no_fwd();

        // sw r3, 8(r2)
        set_instr(1'b1, 6'b101011, 6'd0, 5'd2, 5'd3, 5'd0, 32'h100, 32'hDEAD, 16'h0008);
        tick();
        check("sw op1", ex_op1, 32'h100);
        check("sw op2", ex_op2, 32'h8);
        check("sw store", ex_store_data, 32'hDEAD);
        check("sw ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 32'b0010);
        check("sw dest", {27'd0, ex_dest}, 32'd0);

        // lw r5, -4(r1) then add r6 = r5 + r1
        set_instr(1'b1, 6'b100011, 6'd0, 5'd1, 5'd5, 5'd0, 32'h200, 32'd0, 16'hFFFC);
        tick();
        check("lw op2", ex_op2, 32'hFFFF_FFFC);
        check("lw ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 32'b1100);
        check("lw dest", {27'd0, ex_dest}, 32'd5);
        set_instr(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd1, 5'd6, 32'h999, 32'd1, 16'd0);
        #1;
        check("lu stall", {31'd0, hazard_stall}, 32'd1);
        tick();
        check_bubble("lu bubble");
        mwb_wr_en = 1'b1; mwb_wr_idx = 5'd5; mwb_wr_data = 32'h777;
        #1;
        check("lu stall gone", {31'd0, hazard_stall}, 32'd0);
        tick();
        check("lu add valid", {31'd0, ex_valid}, 32'd1);
        check("lu add op1", ex_op1, 32'h777);
        check("lu add op2", ex_op2, 32'd1);
        check("lu add dest", {27'd0, ex_dest}, 32'd6);
        no_fwd();

        // addi does not read rt, so rt==load dest must not stall
        set_instr(1'b1, 6'b100011, 6'd0, 5'd1, 5'd5, 5'd0, 32'h200, 32'd0, 16'd0);
        tick();
        set_instr(1'b1, 6'b001000, 6'd0, 5'd1, 5'd5, 5'd0, 32'h10, 32'd0, 16'd2);
        #1;
        check("addi rt nostall", {31'd0, hazard_stall}, 32'd0);
        tick();
        check("addi after lw", ex_op1, 32'h10);

        // flush kills beq; then an unflushed beq
        set_instr(1'b1, 6'b000100, 6'd0, 5'd1, 5'd2, 5'd0, 32'h3, 32'h4, 16'h10);
        flush = 1'b1;
        tick();
        check_bubble("flush beq");
        flush = 1'b0;
        tick();
        check("beq ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, 32'b0001);
        check("beq op2", ex_op2, 32'h4);
        check("beq sel", {26'd0, ex_sel}, 32'h04);

        // flush together with a load-use stall
        set_instr(1'b1, 6'b100011, 6'd0, 5'd1, 5'd5, 5'd0, 32'h200, 32'd0, 16'd0);
        tick();
        set_instr(1'b1, 6'b000000, 6'b100000, 5'd2, 5'd5, 5'd6, 32'd1, 32'd2, 16'd0);
        flush = 1'b1;
        #1;
        check("flush+stall hz", {31'd0, hazard_stall}, 32'd1);
        tick();
        check_bubble("flush+stall");
        flush = 1'b0;

        // unsupported opcode and idle decode
        set_instr(1'b1, 6'b000010, 6'd0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'd0);
        tick();
        check_bubble("bad opcode");
        set_instr(1'b0, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'd0);
        tick();
        check_bubble("no valid");

        // asynchronous reset mid-stream
        set_instr(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 32'd9, 32'd9, 16'd0);
        tick();
        check("pre-reset valid", {31'd0, ex_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async rst valid", {31'd0, ex_valid}, 32'd0);
        check("async rst op1", ex_op1, 32'd0);
        check("async rst dest", {27'd0, ex_dest}, 32'd0);
        tick();
        #2 reset = 1'b0;
        tick();
        check("post-reset valid", {31'd0, ex_valid}, 32'd1);
        check("post-reset op1", ex_op1, 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
